// File: rtl/mmu_psum_accumulator.sv
// mmu_psum_accumulator: sums acc_len MMU partial-sum beats per lane and hands the result out over valid/ready.
// Define PSUM_ACC_SATURATE_EN to clamp overflowing lanes instead of wrapping.
module mmu_psum_accumulator #(
   parameter int LANES = 16,
   parameter int IN_W  = 20,
   parameter int ACC_W = 24,
   parameter int LEN_W = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [LEN_W-1:0]       acc_len,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*IN_W-1:0]  in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*ACC_W-1:0] out_data,
   output logic                   busy,
   output logic                   ovf
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   state_t state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q [LANES];
   logic [ACC_W-1:0] acc_d [LANES];
   logic [ACC_W-1:0] ext [LANES];
   logic [ACC_W-1:0] sum [LANES];
   logic [ACC_W-1:0] nxt [LANES];
   logic [LANES-1:0] lane_ovf;
   logic ovf_q, ovf_d, beat, first, last;

   assign beat  = in_valid && in_ready;
   assign first = cnt_q == '0;
   // len_q of 0 wraps to all-ones here, giving the full 2^LEN_W beats
   assign last  = cnt_q == len_q - LEN_W'(1);
   assign ovf   = ovf_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         for (int j = 0; j < LANES; j++) acc_q[j] <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? ACCUM : IDLE;
         ACCUM:   state_d = (beat && last) ? DONE : ACCUM;
         DONE:    state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = state_q == ACCUM;
      out_valid = state_q == DONE;
      busy      = state_q != IDLE;
   end

   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         ext[j] = ACC_W'($signed(in_data[j*IN_W +: IN_W]));
         sum[j] = acc_q[j] + ext[j];
         lane_ovf[j] = (acc_q[j][ACC_W-1] == ext[j][ACC_W-1]) && (sum[j][ACC_W-1] != acc_q[j][ACC_W-1]);
`ifdef PSUM_ACC_SATURATE_EN
         nxt[j] = !lane_ovf[j] ? sum[j] :
                  ext[j][ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
         nxt[j] = sum[j];
`endif
      end
   end

   always_comb begin
      len_d = len_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      acc_d = acc_q;
      if (state_q == IDLE && start) begin
         len_d = acc_len;
         cnt_d = '0;
         ovf_d = 1'b0;
      end
      if (beat) begin
         cnt_d = cnt_q + LEN_W'(1);
         ovf_d = ovf_q || (!first && |lane_ovf);
         for (int j = 0; j < LANES; j++) acc_d[j] = first ? ext[j] : nxt[j];
      end
   end

   always_comb begin
      out_data = '0;
      for (int j = 0; j < LANES; j++) out_data[j*ACC_W +: ACC_W] = acc_q[j];
   end
endmodule
